game_ctrl: RTL



---
 rtl/game_ctrl_pkg.sv | 16 +
 rtl/game_ctrl_if.sv | 24 ++
 rtl/game_ctrl_edge_det.sv | 22 ++
 rtl/game_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared types and parameter defaults for the game controller slice.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int unsigned DEF_FRAMES_PER_POINT   = 6;
    localparam int unsigned DEF_POINTS_PER_SPEEDUP = 100;
    localparam int unsigned DEF_SPEED_INIT         = 1;
    localparam int unsigned DEF_SPEED_MAX          = 8;

endpackage

// File: rtl/game_ctrl_if.sv
// Input controls, pixel taps and status outputs of the game controller.
interface game_ctrl_if;

    logic        start;
    logic        vs;
    logic        px_dinosaur;
    logic        px_cactus;
    logic        game_status;
    logic        game_over;
    logic [3:0]  speed;
    logic [15:0] score;
    logic [15:0] high_score;

    modport master (
        output start, vs, px_dinosaur, px_cactus,
        input  game_status, game_over, speed, score, high_score
    );

    modport slave (
        input  start, vs, px_dinosaur, px_cactus,
        output game_status, game_over, speed, score, high_score
    );

endinterface

// File: rtl/game_ctrl_edge_det.sv
// 1-bit edge detector: registered previous value with an async reset value,
// pulse selects rising or falling edge.
module edge_det #(
    parameter logic RST_VAL = 1'b1,
    parameter bit   FALLING = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic pulse
);

    logic q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) q <= RST_VAL;
        else       q <= d;
    end

    assign pulse = FALLING ? (~d & q) : (d & ~q);

endmodule

// File: rtl/game_ctrl.sv
// Game state machine: arms on start, launches on vertical blank, scores
// per frame, speeds up per score step and latches the best score.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int unsigned FRAMES_PER_POINT   = DEF_FRAMES_PER_POINT,
    parameter int unsigned POINTS_PER_SPEEDUP = DEF_POINTS_PER_SPEEDUP,
    parameter int unsigned SPEED_INIT         = DEF_SPEED_INIT,
    parameter int unsigned SPEED_MAX          = DEF_SPEED_MAX
) (
    input  logic         CLK,
    input  logic         RESET,
    game_ctrl_if.slave   bus
);

    localparam int unsigned FCW = (FRAMES_PER_POINT   > 1) ? $clog2(FRAMES_PER_POINT)   : 1;
    localparam int unsigned PCW = (POINTS_PER_SPEEDUP > 1) ? $clog2(POINTS_PER_SPEEDUP) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_POINT - 1);
    localparam logic [PCW-1:0] POINT_LAST = PCW'(POINTS_PER_SPEEDUP - 1);
    localparam logic [3:0]     SPD_INIT   = 4'(SPEED_INIT);
    localparam logic [3:0]     SPD_MAX    = 4'(SPEED_MAX);

    state_t         state;
    logic [FCW-1:0] frame_cnt;
    logic [PCW-1:0] point_cnt;
    logic           start_rise;
    logic           frame_tick;
    logic           collision;

    edge_det #(.RST_VAL(1'b1), .FALLING(1'b0)) u_start_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (bus.start),
        .pulse (start_rise)
    );

    edge_det #(.RST_VAL(1'b1), .FALLING(1'b1)) u_vs_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (bus.vs),
        .pulse (frame_tick)
    );

    assign collision = bus.px_dinosaur & bus.px_cactus;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= IDLE;
            bus.game_status <= 1'b0;
            bus.game_over   <= 1'b0;
            bus.score       <= '0;
            bus.high_score  <= '0;
            bus.speed       <= SPD_INIT;
            frame_cnt       <= '0;
            point_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rise) state <= ARMED;
                end
                ARMED: begin
                    if (frame_tick) begin
                        state           <= RUN;
                        bus.game_status <= 1'b1;
                        bus.score       <= '0;
                        bus.speed       <= SPD_INIT;
                        frame_cnt       <= '0;
                        point_cnt       <= '0;
                    end
                end
                RUN: begin
                    if (collision) begin
                        state           <= OVER;
                        bus.game_status <= 1'b0;
                        bus.game_over   <= 1'b1;
                        if (bus.score > bus.high_score) bus.high_score <= bus.score;
                    end else if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            // point_cnt mirrors score modulo the speed step, so no divider is needed
                            if (bus.score != 16'hFFFF) begin
                                bus.score <= bus.score + 16'd1;
                                if (point_cnt == POINT_LAST) begin
                                    point_cnt <= '0;
                                    if (bus.speed < SPD_MAX) bus.speed <= bus.speed + 4'd1;
                                end else begin
                                    point_cnt <= point_cnt + PCW'(1);
                                end
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FCW'(1);
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        state         <= ARMED;
                        bus.game_over <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
